// File: rtl/axil_seq_pkg.sv
// Shared types and AXI4-Lite constants for the register init sequencer.
package axil_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] WSTRB_ALL   = 4'hF;

endpackage

// File: rtl/axil_lite_txn.sv
// Single-beat AXI4-Lite master engine: one write (AW+W then B) or one read (AR then R) per command.
module axil_lite_txn #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  req_done_o,
  output logic                  rsp_valid_o,
  output logic [1:0]            rsp_resp_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
);

  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_accept, rd_accept;

  always_comb begin
    // A write request is complete once each channel has either handshaken earlier or does so now.
    wr_accept   = (awvalid_q || wvalid_q) && (!awvalid_q || awready_i) && (!wvalid_q || wready_i);
    rd_accept   = arvalid_q && arready_i;
    req_done_o  = wr_accept || rd_accept;
    rsp_valid_o = (bready_q && bvalid_i) || (rready_q && rvalid_i);
    rsp_resp_o  = bready_q ? bresp_i : rresp_i;
    rsp_rdata_o = rdata_i;

    awvalid_d = awvalid_q && !awready_i;
    wvalid_d  = wvalid_q && !wready_i;
    arvalid_d = arvalid_q && !arready_i;
    bready_d  = (bready_q && !bvalid_i) || wr_accept;
    rready_d  = (rready_q && !rvalid_i) || rd_accept;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (cmd_valid_i) begin
      addr_d = cmd_addr_i;
      if (cmd_write_i) begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        wdata_d   = cmd_wdata_i;
      end else begin
        arvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign awaddr_o  = addr_q;
  assign araddr_o  = addr_q;
  assign awvalid_o = awvalid_q;
  assign wdata_o   = wdata_q;
  assign wvalid_o  = wvalid_q;
  assign arvalid_o = arvalid_q;
  assign bready_o  = bready_q;
  assign rready_o  = rready_q;

endmodule

// File: rtl/axil_reg_init_seq.sv
// Writes a fixed register table over AXI4-Lite, reads it back and reports done/error status.
module axil_reg_init_seq
  import axil_seq_pkg::*;
#(
  parameter int unsigned                ADDR_WIDTH = 4,
  parameter int unsigned                DATA_WIDTH = 32,
  parameter int unsigned                NUM_REGS   = 4,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR  = '0,
  parameter logic [NUM_REGS*32-1:0]     INIT_DATA  = {32'h4, 32'h3, 32'h2, 32'h1}
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [3:0]              err_index,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t                state_q, state_d;
  logic [3:0]            idx_q, idx_d, cmd_idx;
  logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [3:0]            err_index_q, err_index_d;
  logic                  cmd_valid, cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata, txn_rdata;
  logic                  txn_req_done, txn_rsp_valid;
  logic [1:0]            txn_resp;

  function automatic logic [DATA_WIDTH-1:0] table_word(input logic [3:0] i);
    return INIT_DATA[DATA_WIDTH*int'(i) +: DATA_WIDTH];
  endfunction

  // Widened so the sum wraps modulo 2^ADDR_WIDTH for any address width.
  function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [3:0] i);
    logic [ADDR_WIDTH+5:0] wide;
    wide = {{ADDR_WIDTH{1'b0}}, i, 2'b00} + {6'b0, BASE_ADDR};
    return wide[ADDR_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_idx     = idx_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_index_d = '0;
          idx_d       = '0;
          cmd_idx     = '0;
          cmd_valid   = 1'b1;
          cmd_write   = 1'b1;
          state_d     = WR_REQ;
        end
      end
      WR_REQ: if (txn_req_done) state_d = WR_RESP;
      WR_RESP: begin
        if (txn_rsp_valid) begin
          if (txn_resp != RESP_OKAY) begin
            error_d     = 1'b1;
            err_index_d = idx_q;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = DONE;
          end else begin
            cmd_idx   = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
            idx_d     = cmd_idx;
            cmd_valid = 1'b1;
            cmd_write = (idx_q != LAST_IDX);
            state_d   = (idx_q == LAST_IDX) ? RD_REQ : WR_REQ;
          end
        end
      end
      RD_REQ: if (txn_req_done) state_d = RD_RESP;
      RD_RESP: begin
        if (txn_rsp_valid) begin
          if (txn_resp != RESP_OKAY || txn_rdata != table_word(idx_q)) begin
            error_d     = 1'b1;
            err_index_d = idx_q;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = DONE;
          end else if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            cmd_idx   = idx_q + 4'd1;
            idx_d     = cmd_idx;
            cmd_valid = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_addr  = reg_addr(cmd_idx);
    cmd_wdata = table_word(cmd_idx);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
    end
  end

  axil_lite_txn #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_txn (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .cmd_valid_i(cmd_valid),
    .cmd_write_i(cmd_write),
    .cmd_addr_i (cmd_addr),
    .cmd_wdata_i(cmd_wdata),
    .req_done_o (txn_req_done),
    .rsp_valid_o(txn_rsp_valid),
    .rsp_resp_o (txn_resp),
    .rsp_rdata_o(txn_rdata),
    .awaddr_o   (M_AXI_AWADDR),
    .awvalid_o  (M_AXI_AWVALID),
    .awready_i  (M_AXI_AWREADY),
    .wdata_o    (M_AXI_WDATA),
    .wvalid_o   (M_AXI_WVALID),
    .wready_i   (M_AXI_WREADY),
    .bresp_i    (M_AXI_BRESP),
    .bvalid_i   (M_AXI_BVALID),
    .bready_o   (M_AXI_BREADY),
    .araddr_o   (M_AXI_ARADDR),
    .arvalid_o  (M_AXI_ARVALID),
    .arready_i  (M_AXI_ARREADY),
    .rdata_i    (M_AXI_RDATA),
    .rresp_i    (M_AXI_RRESP),
    .rvalid_i   (M_AXI_RVALID),
    .rready_o   (M_AXI_RREADY)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_index    = err_index_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = WSTRB_ALL;

endmodule

// File: tb/tb_axil_reg_init_seq.sv
// Scoreboard bench: slave model with configurable ready delays and fault injection; monitor pops expected bus events.
module tb_axil_reg_init_seq;
  import axil_seq_pkg::*;

  logic        ACLK = 1'b0, ARESET = 1'b1, start = 1'b0;
  logic        busy, done, error;
  logic [3:0]  err_index;
  logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_WDATA;
  logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
  logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [31:0] M_AXI_RDATA = '0;

  always #5 ACLK = ~ACLK;

  axil_reg_init_seq #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(32),
    .NUM_REGS  (4)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  typedef enum int {EV_WR, EV_RD, EV_END} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0, n_bad = 0;

  // Slave model configuration and state
  int          aw_delay = 0, w_delay = 0, berr_addr = -1, rbad_addr = -1;
  int          aw_wait = 0, w_wait = 0;
  bit          got_aw = 0, got_w = 0;
  logic [3:0]  s_awaddr = '0;
  logic [31:0] s_wdata = '0;
  logic [31:0] mem [4] = '{default: '0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{kind: k, a: a, d: d});
  endtask

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) push(EV_WR, 32'(4 * i), 32'(i + 1));
  endtask

  task automatic push_reads(input int n);
    for (int i = 0; i < n; i++) push(EV_RD, 32'(4 * i), 32'd0);
  endtask

  task automatic push_normal();
    push_writes(4);
    push_reads(4);
    push(EV_END, 32'd0, 32'd0);
  endtask

  task automatic pop_check(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d a=0x%0h, expected none", k, a);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      chk(e.kind == EV_END ? "end_error" : "event_addr", a, e.a);
      if (e.kind != EV_RD) chk(e.kind == EV_END ? "end_err_index" : "write_data", d, e.d);
    end
  endtask

  // Slave: handshakes are sampled mid-cycle, responses driven just after the following edge.
  initial begin
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [3:0]  aw_a, ar_a;
    logic [31:0] w_d;
    forever begin
      @(negedge ACLK);
      aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
      w_hs  = M_AXI_WVALID && M_AXI_WREADY;
      b_hs  = M_AXI_BVALID && M_AXI_BREADY;
      ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
      r_hs  = M_AXI_RVALID && M_AXI_RREADY;
      aw_a  = M_AXI_AWADDR;
      ar_a  = M_AXI_ARADDR;
      w_d   = M_AXI_WDATA;
      @(posedge ACLK);
      #1;
      if (aw_hs) begin got_aw = 1; s_awaddr = aw_a; aw_wait = 0; end
      if (w_hs) begin got_w = 1; s_wdata = w_d; w_wait = 0; end
      if (b_hs) begin
        M_AXI_BVALID = 1'b0;
        mem[s_awaddr[3:2]] = s_wdata;
        got_aw = 0;
        got_w = 0;
      end
      if (got_aw && got_w && !M_AXI_BVALID) begin
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = (int'(s_awaddr) == berr_addr) ? RESP_SLVERR : RESP_OKAY;
      end
      if (r_hs) M_AXI_RVALID = 1'b0;
      if (ar_hs) begin
        M_AXI_RVALID = 1'b1;
        M_AXI_RRESP  = RESP_OKAY;
        M_AXI_RDATA  = (int'(ar_a) == rbad_addr) ? 32'hDEAD : mem[ar_a[3:2]];
      end
      if (M_AXI_AWVALID && !got_aw) begin
        M_AXI_AWREADY = (aw_wait == aw_delay);
        aw_wait++;
      end else M_AXI_AWREADY = 1'b0;
      if (M_AXI_WVALID && !got_w) begin
        M_AXI_WREADY = (w_wait == w_delay);
        w_wait++;
      end else M_AXI_WREADY = 1'b0;
      M_AXI_ARREADY = M_AXI_ARVALID && !M_AXI_RVALID;
    end
  end

  // Monitor: pops expected events on B/R handshakes and on done rising; checks valid stability.
  initial begin
    logic        done_prev = 1'b0, aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [3:0]  aw_hold = '0, ar_hold = '0, mon_awaddr = '0, mon_araddr = '0;
    logic [31:0] w_hold = '0, mon_wdata = '0;
    forever begin
      @(negedge ACLK);
      if (aw_pend) begin
        chk("awvalid_hold", 32'(M_AXI_AWVALID), 32'd1);
        chk("awaddr_hold", 32'(M_AXI_AWADDR), 32'(aw_hold));
      end
      if (w_pend) begin
        chk("wvalid_hold", 32'(M_AXI_WVALID), 32'd1);
        chk("wdata_hold", M_AXI_WDATA, w_hold);
      end
      if (ar_pend) begin
        chk("arvalid_hold", 32'(M_AXI_ARVALID), 32'd1);
        chk("araddr_hold", 32'(M_AXI_ARADDR), 32'(ar_hold));
      end
      aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY && !ARESET;
      w_pend  = M_AXI_WVALID && !M_AXI_WREADY && !ARESET;
      ar_pend = M_AXI_ARVALID && !M_AXI_ARREADY && !ARESET;
      aw_hold = M_AXI_AWADDR;
      w_hold  = M_AXI_WDATA;
      ar_hold = M_AXI_ARADDR;
      if (M_AXI_AWVALID && M_AXI_AWREADY) mon_awaddr = M_AXI_AWADDR;
      if (M_AXI_WVALID && M_AXI_WREADY) mon_wdata = M_AXI_WDATA;
      if (M_AXI_ARVALID && M_AXI_ARREADY) mon_araddr = M_AXI_ARADDR;
      if (M_AXI_BVALID && M_AXI_BREADY) pop_check(EV_WR, 32'(mon_awaddr), mon_wdata);
      if (M_AXI_RVALID && M_AXI_RREADY) pop_check(EV_RD, 32'(mon_araddr), 32'd0);
      if (done && !done_prev) pop_check(EV_END, 32'(error), 32'(err_index));
      done_prev = done;
    end
  end

  task automatic start_seq();
    @(negedge ACLK);
    start = 1'b1;
    @(posedge ACLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge ACLK);
      #1;
      n++;
      if (done) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_done: done=0 after 400 cycles, expected 1");
  endtask

  task automatic settle();
    repeat (3) @(posedge ACLK);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_idle_bus(input string name);
    chk(name, {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 32'd0);
  endtask

  initial begin
    int n;
    bit found;
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_status", {28'd0, busy, done, error, 1'b0}, 32'd0);
    chk("rst_err_index", 32'(err_index), 32'd0);
    chk_idle_bus("rst_bus");
    chk("rst_wstrb", 32'(M_AXI_WSTRB), 32'hF);
    chk("rst_prot", {26'd0, M_AXI_AWPROT, M_AXI_ARPROT}, 32'd0);
    chk("rst_addr_data", M_AXI_WDATA | 32'(M_AXI_AWADDR), 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;

    // Zero-wait slave: latency and data
    push_normal();
    start_seq();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_aw_w_valid", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd3);
    chk("start_awaddr", 32'(M_AXI_AWADDR), 32'd0);
    chk("start_wdata", M_AXI_WDATA, 32'd1);
    wait_done(n);
    chk("done_latency", 32'(n), 32'd16);
    chk("ok_error", 32'(error), 32'd0);
    chk("ok_busy", 32'(busy), 32'd0);
    settle();

    // Start pulses while busy are ignored
    push_normal();
    start_seq();
    @(negedge ACLK); start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    repeat (6) @(negedge ACLK);
    start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    wait_done(n);
    chk("busy_start_latency", 32'(n), 32'd8);
    settle();

    // AWREADY delayed 3 cycles, WREADY immediate
    aw_delay = 3;
    push_normal();
    start_seq();
    @(posedge ACLK); #1;
    chk("awdly_w_drop", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd2);
    repeat (2) @(posedge ACLK);
    #1;
    chk("awdly_aw_held", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd2);
    @(posedge ACLK); #1;
    chk("awdly_aw_drop", {30'd0, M_AXI_AWVALID, M_AXI_BREADY}, 32'd1);
    wait_done(n);
    chk("awdly_error", 32'(error), 32'd0);
    settle();
    aw_delay = 0;

    // WREADY delayed 3 cycles, AWREADY immediate
    w_delay = 3;
    push_normal();
    start_seq();
    @(posedge ACLK); #1;
    chk("wdly_aw_drop", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd1);
    repeat (2) @(posedge ACLK);
    #1;
    chk("wdly_w_held", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd1);
    @(posedge ACLK); #1;
    chk("wdly_w_drop", {30'd0, M_AXI_WVALID, M_AXI_BREADY}, 32'd1);
    wait_done(n);
    chk("wdly_error", 32'(error), 32'd0);
    settle();
    w_delay = 0;

    // SLVERR on write index 2: abort with no reads
    berr_addr = 8;
    push_writes(3);
    push(EV_END, 32'd1, 32'd2);
    start_seq();
    wait_done(n);
    chk("werr_status", {29'd0, busy, done, error}, 32'd3);
    chk("werr_index", 32'(err_index), 32'd2);
    settle();
    berr_addr = -1;

    // Start from DONE clears error and reruns
    push_normal();
    start_seq();
    chk("restart_status", {28'd0, busy, done, error, 1'b0}, 32'd8);
    chk("restart_err_index", 32'(err_index), 32'd0);
    wait_done(n);
    chk("restart_error", 32'(error), 32'd0);
    settle();

    // Readback mismatch on index 3
    rbad_addr = 12;
    push_writes(4);
    push_reads(4);
    push(EV_END, 32'd1, 32'd3);
    start_seq();
    wait_done(n);
    chk("rbad_index", 32'(err_index), 32'd3);
    chk("rbad_error", 32'(error), 32'd1);
    settle();
    rbad_addr = -1;

    // Reset during WR_RESP of index 1
    push_writes(2);
    start_seq();
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge ACLK); #1;
      found = M_AXI_BREADY && (M_AXI_AWADDR == 4'h4);
    end
    chk("midrst_reached", 32'(found), 32'd1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk_idle_bus("midrst_bus");
    chk("midrst_status", {30'd0, busy, done}, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    settle();
    push_normal();
    start_seq();
    wait_done(n);
    chk("after_rst_latency", 32'(n), 32'd16);
    chk("after_rst_error", 32'(error), 32'd0);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
